bp_axi_dma_arbiter: RTL and testbench



---
 rtl/bp_axi_dma_arbiter_if.sv | 39 +++
 rtl/bp_axi_dma_arbiter.sv | 158 +++++++++++++++
 tb/tb_bp_axi_dma_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_axi_dma_arbiter_if.sv
// rtl/bp_axi_dma_arbiter_if.sv - requester-side and channel-side DMA bus of the arbiter
interface bp_axi_dma_arbiter_if #(
    parameter int num_req_p    = 4,
    parameter int addr_width_p = 40,
    parameter int data_width_p = 64
);
    logic [num_req_p-1:0][addr_width_p:0]   dma_pkt_i;
    logic [num_req_p-1:0]                   dma_pkt_v_i;
    logic [num_req_p-1:0]                   dma_pkt_yumi_o;
    logic [num_req_p-1:0][data_width_p-1:0] dma_wdata_i;
    logic [num_req_p-1:0]                   dma_wdata_v_i;
    logic [num_req_p-1:0]                   dma_wdata_yumi_o;
    logic [data_width_p-1:0]                dma_rdata_o;
    logic [num_req_p-1:0]                   dma_rdata_v_o;
    logic [num_req_p-1:0]                   dma_rdata_ready_and_i;
    logic [addr_width_p:0]                  pkt_o;
    logic                                   pkt_v_o;
    logic                                   pkt_ready_and_i;
    logic [data_width_p-1:0]                wdata_o;
    logic                                   wdata_v_o;
    logic                                   wdata_ready_and_i;
    logic [data_width_p-1:0]                rdata_i;
    logic                                   rdata_v_i;
    logic                                   rdata_ready_and_o;

    modport slave (
        input  dma_pkt_i, dma_pkt_v_i, dma_wdata_i, dma_wdata_v_i, dma_rdata_ready_and_i,
               pkt_ready_and_i, wdata_ready_and_i, rdata_i, rdata_v_i,
        output dma_pkt_yumi_o, dma_wdata_yumi_o, dma_rdata_o, dma_rdata_v_o,
               pkt_o, pkt_v_o, wdata_o, wdata_v_o, rdata_ready_and_o
    );

    modport master (
        output dma_pkt_i, dma_pkt_v_i, dma_wdata_i, dma_wdata_v_i, dma_rdata_ready_and_i,
               pkt_ready_and_i, wdata_ready_and_i, rdata_i, rdata_v_i,
        input  dma_pkt_yumi_o, dma_wdata_yumi_o, dma_rdata_o, dma_rdata_v_o,
               pkt_o, pkt_v_o, wdata_o, wdata_v_o, rdata_ready_and_o
    );
endinterface

// File: rtl/bp_axi_dma_arbiter.sv
// rtl/bp_axi_dma_arbiter.sv - round-robin share of one DMA channel among cache requesters
// One packet in flight at a time; writes lock the data path for a block, reads return in issue order.
module bp_axi_dma_arbiter #(
    parameter int num_req_p     = 4,
    parameter int addr_width_p  = 40,
    parameter int data_width_p  = 64,
    parameter int block_beats_p = 8,
    parameter int max_reads_p   = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_axi_dma_arbiter_if.slave     bus
);
    localparam int id_w  = $clog2(num_req_p);
    localparam int cnt_w = $clog2(block_beats_p);
    localparam int occ_w = $clog2(max_reads_p + 1);
    localparam int ptr_w = (max_reads_p > 1) ? $clog2(max_reads_p) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WDATA} state_e;

    state_e                 state_q, state_d;
    logic [id_w-1:0]        rr_ptr_q, rr_ptr_d;
    logic [id_w-1:0]        owner_q, owner_d;
    logic [addr_width_p:0]  pkt_q, pkt_d;
    logic [cnt_w-1:0]       wbeat_q, wbeat_d;
    logic [cnt_w-1:0]       rbeat_q;
    logic [id_w-1:0]        fifo_mem_q [max_reads_p];
    logic [ptr_w-1:0]       fifo_rd_q, fifo_wr_q;
    logic [occ_w-1:0]       read_cnt_q;

    logic [num_req_p-1:0]   eligible;
    logic                   grant_found;
    logic [id_w-1:0]        grant_id;
    logic                   w_hs, push, pop, r_hs, fifo_nonempty;
    logic [id_w-1:0]        head;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(max_reads_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reads are held back once the ID FIFO could not accept another owner.
    always_comb begin
        for (int i = 0; i < num_req_p; i++) begin
            eligible[i] = bus.dma_pkt_v_i[i]
                        & (bus.dma_pkt_i[i][addr_width_p] | (read_cnt_q < occ_w'(max_reads_p)));
        end
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = (int'(rr_ptr_q) + k) % num_req_p;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_id    = id_w'(idx);
            end
        end
    end

    assign w_hs = (state_q == WDATA) & bus.dma_wdata_v_i[owner_q] & bus.wdata_ready_and_i;
    assign push = (state_q == ISSUE) & bus.pkt_ready_and_i & ~pkt_q[addr_width_p];

    always_comb begin
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        owner_d            = owner_q;
        pkt_d              = pkt_q;
        wbeat_d            = wbeat_q;
        bus.dma_pkt_yumi_o = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_found && !reset_i) begin
                    bus.dma_pkt_yumi_o[grant_id] = 1'b1;
                    pkt_d    = bus.dma_pkt_i[grant_id];
                    owner_d  = grant_id;
                    rr_ptr_d = (grant_id == id_w'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.pkt_ready_and_i) begin
                    state_d = pkt_q[addr_width_p] ? WDATA : IDLE;
                    wbeat_d = '0;
                end
            end
            WDATA: begin
                if (w_hs) begin
                    if (wbeat_q == cnt_w'(block_beats_p - 1)) begin
                        state_d = IDLE;
                        wbeat_d = '0;
                    end else begin
                        wbeat_d = wbeat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.pkt_v_o          = (state_q == ISSUE);
        bus.pkt_o            = pkt_q;
        bus.wdata_v_o        = (state_q == WDATA) & bus.dma_wdata_v_i[owner_q];
        bus.wdata_o          = (state_q == WDATA) ? bus.dma_wdata_i[owner_q] : '0;
        bus.dma_wdata_yumi_o = '0;
        bus.dma_wdata_yumi_o[owner_q] = w_hs;
    end

    // Return path steers by FIFO head only; it never looks at the issue FSM.
    assign fifo_nonempty         = (read_cnt_q != '0);
    assign head                  = fifo_mem_q[fifo_rd_q];
    assign bus.dma_rdata_o       = bus.rdata_i;
    assign bus.rdata_ready_and_o = fifo_nonempty & bus.dma_rdata_ready_and_i[head];
    assign r_hs                  = fifo_nonempty & bus.rdata_v_i & bus.dma_rdata_ready_and_i[head];
    assign pop                   = r_hs & (rbeat_q == cnt_w'(block_beats_p - 1));

    always_comb begin
        bus.dma_rdata_v_o = '0;
        if (fifo_nonempty) bus.dma_rdata_v_o[head] = bus.rdata_v_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            pkt_q      <= '0;
            wbeat_q    <= '0;
            rbeat_q    <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            read_cnt_q <= '0;
            for (int i = 0; i < max_reads_p; i++) fifo_mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            pkt_q    <= pkt_d;
            wbeat_q  <= wbeat_d;
            if (r_hs) rbeat_q <= pop ? '0 : rbeat_q + 1'b1;
            if (push) begin
                fifo_mem_q[fifo_wr_q] <= owner_q;
                fifo_wr_q             <= ptr_inc(fifo_wr_q);
            end
            if (pop) fifo_rd_q <= ptr_inc(fifo_rd_q);
            if (push && !pop)      read_cnt_q <= read_cnt_q + 1'b1;
            else if (pop && !push) read_cnt_q <= read_cnt_q - 1'b1;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push && !pop && read_cnt_q == occ_w'(max_reads_p)));
    a_no_orphan_rdata: assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.rdata_v_i && !fifo_nonempty));
endmodule

// File: tb/tb_bp_axi_dma_arbiter.sv
// tb/tb_bp_axi_dma_arbiter.sv - randomized scenario bench for bp_axi_dma_arbiter
module tb_bp_axi_dma_arbiter;
    localparam int NR = 4, AW = 40, DW = 64, BB = 8, MR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_axi_dma_arbiter_if #(.num_req_p(NR), .addr_width_p(AW), .data_width_p(DW)) bus();

    bp_axi_dma_arbiter #(.num_req_p(NR), .addr_width_p(AW), .data_width_p(DW),
                         .block_beats_p(BB), .max_reads_p(MR))
        dut (.clk_i(clk), .reset_i(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: rotating priority pointer and the ordered list of outstanding read owners.
    int m_rr = 0;
    int m_q[$];
    logic [AW-1:0] req_addr [NR];

    function automatic int model_pick(input logic [NR-1:0] v, input logic [NR-1:0] w);
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_rr + k) % NR;
            if (v[i] && (w[i] || m_q.size() < MR)) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dma_pkt_i             = '0;
        bus.dma_pkt_v_i           = '0;
        bus.dma_wdata_i           = '0;
        bus.dma_wdata_v_i         = '0;
        bus.dma_rdata_ready_and_i = '0;
        bus.pkt_ready_and_i       = 1'b0;
        bus.wdata_ready_and_i     = 1'b0;
        bus.rdata_i               = '0;
        bus.rdata_v_i             = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_rr = 0;
        m_q.delete();
    endtask

    task automatic grant(input logic [NR-1:0] v, input logic [NR-1:0] w, output int win);
        logic [NR-1:0] exp;
        for (int i = 0; i < NR; i++) bus.dma_pkt_i[i] = {w[i], req_addr[i]};
        bus.dma_pkt_v_i = v;
        @(negedge clk);
        win = model_pick(v, w);
        exp = '0;
        if (win >= 0) exp[win] = 1'b1;
        n_tests++;
        if (bus.dma_pkt_yumi_o !== exp) begin
            n_fail++;
            $display("FAIL grant: yumi=%b expected %b", bus.dma_pkt_yumi_o, exp);
        end
        tick();
        if (win >= 0) m_rr = (win + 1) % NR;
    endtask

    task automatic issue(input int win, input logic w, input int lat, input logic [NR-1:0] hold_v);
        logic [AW:0] exp_pkt;
        exp_pkt = {w, req_addr[win]};
        bus.dma_pkt_v_i = hold_v;
        for (int c = 0; c <= lat; c++) begin
            bus.pkt_ready_and_i = (c == lat);
            @(negedge clk);
            n_tests++;
            if (bus.pkt_v_o !== 1'b1 || bus.pkt_o !== exp_pkt || bus.dma_pkt_yumi_o !== '0) begin
                n_fail++;
                $display("FAIL issue: pkt_v=%b pkt=%h yumi=%b expected 1 %h 0000",
                         bus.pkt_v_o, bus.pkt_o, bus.dma_pkt_yumi_o, exp_pkt);
            end
            tick();
        end
        bus.pkt_ready_and_i = 1'b0;
        if (!w) m_q.push_back(win);
    endtask

    task automatic return_block(input int stall);
        int head, beats, cyc, stall_left;
        logic v;
        logic [DW-1:0] d;
        logic [NR-1:0] rdy, exp_v;
        head = m_q[0];
        beats = 0;
        cyc = 0;
        stall_left = stall;
        while (beats < BB && cyc < 300) begin
            v = (($urandom % 4) != 0);
            d = {$urandom, $urandom};
            rdy = NR'($urandom);
            rdy[head] = (($urandom % 4) != 0);
            if (head == 0 && beats == 3 && stall_left > 0) begin
                rdy[0] = 1'b0;
                v = 1'b1;
                stall_left--;
            end
            bus.rdata_v_i = v;
            bus.rdata_i = d;
            bus.dma_rdata_ready_and_i = rdy;
            @(negedge clk);
            exp_v = '0;
            if (v) exp_v[head] = 1'b1;
            n_tests++;
            if (bus.dma_rdata_v_o !== exp_v || bus.rdata_ready_and_o !== rdy[head]
                || (v && bus.dma_rdata_o !== d)) begin
                n_fail++;
                $display("FAIL rdata_route: v=%b rdy=%b data=%h expected %b %b %h",
                         bus.dma_rdata_v_o, bus.rdata_ready_and_o, bus.dma_rdata_o, exp_v, rdy[head], d);
            end
            if (v && rdy[head]) beats++;
            tick();
            cyc++;
        end
        bus.rdata_v_i = 1'b0;
        bus.dma_rdata_ready_and_i = '0;
        n_tests++;
        if (beats != BB) begin
            n_fail++;
            $display("FAIL rdata_timeout: beats=%0d expected %0d", beats, BB);
        end
        void'(m_q.pop_front());
    endtask

    task automatic check_fifo_empty(input string tag);
        bus.rdata_v_i = 1'b0;
        bus.dma_rdata_ready_and_i = '1;
        @(negedge clk);
        n_tests++;
        if (bus.rdata_ready_and_o !== 1'b0 || bus.dma_rdata_v_o !== '0) begin
            n_fail++;
            $display("FAIL %s: rready=%b rv=%b expected 0 0000", tag, bus.rdata_ready_and_o, bus.dma_rdata_v_o);
        end
        tick();
        bus.dma_rdata_ready_and_i = '0;
    endtask

    task automatic check_quiet(input string tag);
        n_tests++;
        if (bus.pkt_v_o !== 1'b0 || bus.dma_pkt_yumi_o !== '0 || bus.wdata_v_o !== 1'b0
            || bus.dma_wdata_yumi_o !== '0 || bus.rdata_ready_and_o !== 1'b0
            || bus.dma_rdata_v_o !== '0 || bus.pkt_o !== '0) begin
            n_fail++;
            $display("FAIL %s: pkt_v=%b yumi=%b wv=%b wyumi=%b rready=%b rv=%b pkt=%h expected all 0",
                     tag, bus.pkt_v_o, bus.dma_pkt_yumi_o, bus.wdata_v_o, bus.dma_wdata_yumi_o,
                     bus.rdata_ready_and_o, bus.dma_rdata_v_o, bus.pkt_o);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.dma_pkt_v_i = '1;
        bus.dma_wdata_v_i = '1;
        bus.dma_rdata_ready_and_i = '1;
        bus.pkt_ready_and_i = 1'b1;
        bus.wdata_ready_and_i = 1'b1;
        tick();
        @(negedge clk);
        check_quiet("reset_state");
        do_reset();
    endtask

    task automatic test_single_read();
        int win;
        logic [NR-1:0] v;
        req_addr[2] = 40'h80;
        grant(4'b0100, 4'b0000, win);
        issue(2, 1'b0, int'($urandom_range(0, 2)), '0);
        return_block(0);
        check_fifo_empty("single_read_empty");
        for (int i = 0; i < NR; i++) req_addr[i] = {8'h0, $urandom};
        grant(4'b1111, 4'b0000, win);
        n_tests++;
        if (win != 3) begin
            n_fail++;
            $display("FAIL rr_after_single: model winner=%0d expected 3", win);
        end
        issue(win, 1'b0, 0, '0);
        return_block(0);
        repeat (4) begin
            int k;
            k = int'($urandom_range(1, 3));
            for (int j = 0; j < k; j++) begin
                for (int i = 0; i < NR; i++) req_addr[i] = {8'h0, $urandom};
                v = NR'($urandom_range(1, 15));
                grant(v, 4'b0000, win);
                issue(win, 1'b0, int'($urandom_range(0, 2)), '0);
            end
            while (m_q.size() > 0) return_block(0);
        end
    endtask

    task automatic test_round_robin();
        int win;
        do_reset();
        for (int i = 0; i < NR; i++) req_addr[i] = {8'h0, $urandom};
        for (int g = 0; g < NR; g++) begin
            grant(4'b1111, 4'b0000, win);
            n_tests++;
            if (win != g) begin
                n_fail++;
                $display("FAIL rr_order: winner=%0d expected %0d", win, g);
            end
            issue(win, 1'b0, 0, 4'b1111);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.dma_pkt_yumi_o !== '0) begin
                n_fail++;
                $display("FAIL rr_withheld: yumi=%b expected 0000", bus.dma_pkt_yumi_o);
            end
            tick();
        end
        for (int b = 0; b < BB; b++) begin
            bus.rdata_v_i = 1'b1;
            bus.rdata_i = {$urandom, $urandom};
            bus.dma_rdata_ready_and_i = '1;
            @(negedge clk);
            n_tests++;
            if (bus.dma_pkt_yumi_o !== '0 || bus.dma_rdata_v_o !== 4'b0001) begin
                n_fail++;
                $display("FAIL rr_block0: yumi=%b rv=%b expected 0000 0001", bus.dma_pkt_yumi_o, bus.dma_rdata_v_o);
            end
            tick();
        end
        bus.rdata_v_i = 1'b0;
        bus.dma_rdata_ready_and_i = '0;
        void'(m_q.pop_front());
        grant(4'b1111, 4'b0000, win);
        issue(win, 1'b0, 0, '0);
        while (m_q.size() > 0) return_block(0);
    endtask

    task automatic test_write_lock();
        int win, hs, cyc;
        logic wr;
        logic [NR-1:0] exp_y;
        req_addr[1] = {8'h0, $urandom};
        req_addr[3] = {8'h0, $urandom};
        grant(4'b0010, 4'b0010, win);
        issue(1, 1'b1, 1, 4'b1000);
        hs = 0;
        cyc = 0;
        while (hs < BB && cyc < 40) begin
            wr = (cyc % 2 == 0);
            bus.wdata_ready_and_i = wr;
            for (int i = 0; i < NR; i++) bus.dma_wdata_i[i] = {$urandom, $urandom};
            bus.dma_wdata_v_i = NR'($urandom) | 4'b0010;
            @(negedge clk);
            exp_y = wr ? 4'b0010 : 4'b0000;
            n_tests++;
            if (bus.wdata_v_o !== 1'b1 || bus.wdata_o !== bus.dma_wdata_i[1]
                || bus.dma_wdata_yumi_o !== exp_y || bus.dma_pkt_yumi_o !== '0) begin
                n_fail++;
                $display("FAIL write_lock: wv=%b wdata=%h wyumi=%b pyumi=%b expected 1 %h %b 0000",
                         bus.wdata_v_o, bus.wdata_o, bus.dma_wdata_yumi_o, bus.dma_pkt_yumi_o,
                         bus.dma_wdata_i[1], exp_y);
            end
            if (wr) hs++;
            tick();
            cyc++;
        end
        bus.wdata_ready_and_i = 1'b0;
        bus.dma_wdata_v_i = '0;
        grant(4'b1000, 4'b0000, win);
        issue(3, 1'b0, 0, '0);
        return_block(0);
    endtask

    task automatic test_interleaved();
        int win;
        int order[3] = '{3, 0, 3};
        for (int j = 0; j < 3; j++) begin
            req_addr[order[j]] = {8'h0, $urandom};
            grant(NR'(1) << order[j], 4'b0000, win);
            issue(order[j], 1'b0, int'($urandom_range(0, 1)), '0);
        end
        for (int j = 0; j < 3; j++) return_block(5);
        check_fifo_empty("interleaved_empty");
    endtask

    task automatic test_push_pop();
        int win;
        req_addr[1] = {8'h0, $urandom};
        req_addr[2] = {8'h0, $urandom};
        grant(4'b0010, 4'b0000, win);
        issue(1, 1'b0, 0, '0);
        bus.rdata_v_i = 1'b1;
        bus.dma_rdata_ready_and_i = '1;
        for (int b = 0; b < BB - 2; b++) begin
            bus.rdata_i = {$urandom, $urandom};
            tick();
        end
        grant(4'b0100, 4'b0000, win);
        bus.dma_pkt_v_i = '0;
        bus.pkt_ready_and_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.pkt_v_o !== 1'b1 || bus.pkt_o !== {1'b0, req_addr[2]} || bus.dma_rdata_v_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL push_pop_cycle: pkt_v=%b pkt=%h rv=%b expected 1 %h 0010",
                     bus.pkt_v_o, bus.pkt_o, bus.dma_rdata_v_o, {1'b0, req_addr[2]});
        end
        tick();
        bus.pkt_ready_and_i = 1'b0;
        bus.rdata_v_i = 1'b0;
        void'(m_q.pop_front());
        m_q.push_back(2);
        return_block(0);
        check_fifo_empty("push_pop_empty");
    endtask

    task automatic test_async_reset();
        int win;
        req_addr[0] = {8'h0, $urandom};
        grant(4'b0001, 4'b0001, win);
        issue(0, 1'b1, 0, '0);
        bus.wdata_ready_and_i = 1'b1;
        bus.dma_wdata_v_i = 4'b0001;
        for (int b = 0; b < 3; b++) begin
            bus.dma_wdata_i[0] = {$urandom, $urandom};
            tick();
        end
        bus.dma_pkt_v_i = '1;
        @(negedge clk);
        n_tests++;
        if (bus.wdata_v_o !== 1'b1 || bus.dma_wdata_yumi_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL pre_reset_beat3: wv=%b wyumi=%b expected 1 0001", bus.wdata_v_o, bus.dma_wdata_yumi_o);
        end
        #1 rst = 1'b1;
        #1 check_quiet("async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();
        m_rr = 0;
        m_q.delete();
        for (int i = 0; i < NR; i++) req_addr[i] = {8'h0, $urandom};
        grant(4'b1111, 4'b0000, win);
        n_tests++;
        if (win != 0) begin
            n_fail++;
            $display("FAIL post_reset_first: model winner=%0d expected 0", win);
        end
        issue(win, 1'b0, 0, '0);
        return_block(0);
        check_fifo_empty("post_reset_empty");
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < NR; i++) req_addr[i] = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_lock();
        test_interleaved();
        test_push_pop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
